buzzer_sched: RTL

Sound scheduler for the clock's single piezo buzzer. Four sources need the buzzer: alarm (time-up), hourly chime, key click and per-second tick. This block arbitrates between them and sequences each source's on/off beep pattern. It drives the resulting tone half-period into an internal square-wave tone generator, which outputs BUZZER. It sits between the timekeeping/alarm/key logic and the buzzer pin.

---
 rtl/buzzer_pkg.sv | 52 +++++
 rtl/buzzer_sched_if.sv | 28 ++
 rtl/buzzer_tone_gen.sv | 45 ++++
 rtl/buzzer_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared encodings and pattern constants for the buzzer scheduler.
// TICK_HALF exists only when BUZZER_TICK_EN is defined.
package buzzer_pkg;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_ALARM = 3'd1,
    SRC_CHIME = 3'd2,
    SRC_KEY   = 3'd3,
    SRC_TICK  = 3'd4
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [17:0] ALARM_HALF = 18'd12000;
  localparam logic [17:0] CHIME_HALF = 18'd45801;
  localparam logic [17:0] KEY_HALF   = 18'd22900;
`ifdef BUZZER_TICK_EN
  localparam logic [17:0] TICK_HALF  = 18'd91603;
`endif

  localparam logic [1:0] ALARM_ON_SLOTS  = 2'd2;
  localparam logic [1:0] ALARM_OFF_SLOTS = 2'd2;
  localparam logic [1:0] CHIME_ON        = 2'd1;
  localparam logic [1:0] CHIME_OFF       = 2'd2;
  localparam logic [3:0] MAX_CHIME       = 4'd12;

  // An hour of 0 or beyond 12 still chimes twelve times.
  function automatic logic [3:0] norm_hour(input logic [3:0] h);
    return ((h == 4'd0) || (h > MAX_CHIME)) ? MAX_CHIME : h;
  endfunction

  // Tone half-period for a sounding source; NONE (and TICK when disabled) is silent.
  function automatic logic [17:0] half_of(input src_e s);
    logic [17:0] h;
    case (s)
      SRC_ALARM: h = ALARM_HALF;
      SRC_CHIME: h = CHIME_HALF;
      SRC_KEY:   h = KEY_HALF;
`ifdef BUZZER_TICK_EN
      SRC_TICK:  h = TICK_HALF;
`endif
      default:   h = 18'd0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/buzzer_sched_if.sv
// buzzer_sched_if: request inputs and sound outputs of the buzzer scheduler.
// Requests are level (req_alarm) or single-cycle pulses sampled on every rising
// CLK edge; there is no back-pressure, a pulse that cannot start is latched or dropped.
interface buzzer_sched_if;
  import buzzer_pkg::*;

  logic        req_alarm;
  logic        alarm_stop;
  logic        req_chime;
  logic [3:0]  chime_hour;
  logic        req_key;
  logic        req_tick;
  logic [17:0] tone_half;
  logic [2:0]  active_src;
  logic        busy;
  logic        BUZZER;
  state_e      state_dbg;

  modport master (
    output req_alarm, alarm_stop, req_chime, chime_hour, req_key, req_tick,
    input  tone_half, active_src, busy, BUZZER, state_dbg
  );

  modport slave (
    input  req_alarm, alarm_stop, req_chime, chime_hour, req_key, req_tick,
    output tone_half, active_src, busy, BUZZER, state_dbg
  );
endinterface

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: square wave whose half-period is tone_half cycles.
// A zero half-period silences the output; any change restarts the count.
module buzzer_tone_gen (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [17:0] tone_half,
  output logic        BUZZER
);

  logic [17:0] cnt_q, cnt_d;
  logic [17:0] half_q, half_d;
  logic        buz_q, buz_d;
  logic [17:0] cnt_eff;

  // Counter state; the cycle in which tone_half changes counts as count 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      half_q <= '0;
      buz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      buz_q  <= buz_d;
    end
  end

  // Count to tone_half-1, toggle and wrap; silence forces everything low.
  always_comb begin
    cnt_eff = (tone_half == half_q) ? cnt_q : 18'd0;
    half_d  = tone_half;
    cnt_d   = cnt_eff + 18'd1;
    buz_d   = buz_q;
    if (tone_half == 18'd0) begin
      cnt_d = '0;
      buz_d = 1'b0;
    end else if (cnt_eff == tone_half - 18'd1) begin
      cnt_d = '0;
      buz_d = ~buz_q;
    end
  end

  assign BUZZER = buz_q;

endmodule

// File: rtl/buzzer_sched.sv
// buzzer_sched: arbitrates alarm/chime/key/tick and sequences their beep patterns.
// Optional feature: define BUZZER_TICK_EN to honour req_tick; otherwise it is ignored.
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int SLOT_CYC = 2400000
) (
  input  logic CLK,
  input  logic nRST,
  buzzer_sched_if.slave bus
);

  localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic [3:0]        beeps_q, beeps_d;
  logic              chime_pend_q, chime_pend_d;
  logic [3:0]        chime_hour_q, chime_hour_d;
  logic              key_pend_q, key_pend_d;
  logic              stopped_q, stopped_d;

  logic       alarm_go, tick_go, slot_tc, end_alarm, go_idle;
  logic       chime_take, key_take;
  logic [3:0] hour_in;

`ifdef BUZZER_TICK_EN
  assign tick_go = bus.req_tick;
`else
  logic unused_tick;
  assign unused_tick = bus.req_tick;
  assign tick_go     = 1'b0;
`endif

  // State register: sequencing, pending latches and the alarm-stop flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      slot_cnt_q   <= '0;
      phase_q      <= '0;
      beeps_q      <= '0;
      chime_pend_q <= 1'b0;
      chime_hour_q <= '0;
      key_pend_q   <= 1'b0;
      stopped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      slot_cnt_q   <= slot_cnt_d;
      phase_q      <= phase_d;
      beeps_q      <= beeps_d;
      chime_pend_q <= chime_pend_d;
      chime_hour_q <= chime_hour_d;
      key_pend_q   <= key_pend_d;
      stopped_q    <= stopped_d;
    end
  end

  // Next state: alarm preemption, start from IDLE, phase stepping at slot ends.
  always_comb begin
    alarm_go     = bus.req_alarm & ~stopped_q & ~bus.alarm_stop;
    slot_tc      = (slot_cnt_q == SLOT_W'(SLOT_CYC - 1));
    end_alarm    = stopped_q | bus.alarm_stop | ~bus.req_alarm;
    hour_in      = norm_hour(bus.chime_hour);
    state_d      = state_q;
    src_d        = src_q;
    slot_cnt_d   = slot_cnt_q;
    phase_d      = phase_q;
    beeps_d      = beeps_q;
    chime_pend_d = chime_pend_q;
    chime_hour_d = chime_hour_q;
    key_pend_d   = key_pend_q;
    stopped_d    = (stopped_q | bus.alarm_stop) & bus.req_alarm;
    chime_take   = 1'b0;
    key_take     = 1'b0;
    go_idle      = 1'b0;

    if (alarm_go && (src_q != SRC_ALARM)) begin
      // Any running sequence is abandoned; pending bits are untouched.
      state_d    = ST_ON;
      src_d      = SRC_ALARM;
      slot_cnt_d = '0;
      phase_d    = ALARM_ON_SLOTS;
      beeps_d    = '0;
    end else if (state_q == ST_IDLE) begin
      slot_cnt_d = '0;
      if (bus.req_chime || chime_pend_q) begin
        chime_take   = bus.req_chime;
        chime_pend_d = 1'b0;
        state_d      = ST_ON;
        src_d        = SRC_CHIME;
        phase_d      = CHIME_ON;
        beeps_d      = bus.req_chime ? hour_in : chime_hour_q;
      end else if (bus.req_key || key_pend_q) begin
        key_take   = bus.req_key;
        key_pend_d = 1'b0;
        state_d    = ST_ON;
        src_d      = SRC_KEY;
        phase_d    = 2'd1;
      end else if (tick_go) begin
        state_d = ST_ON;
        src_d   = SRC_TICK;
        phase_d = 2'd1;
      end
    end else begin
      slot_cnt_d = slot_tc ? '0 : slot_cnt_q + SLOT_W'(1);
      if (slot_tc) begin
        case (src_q)
          SRC_ALARM: begin
            if (end_alarm) begin
              go_idle = 1'b1;
            end else if (phase_q != 2'd1) begin
              phase_d = phase_q - 2'd1;
            end else if (state_q == ST_ON) begin
              state_d = ST_OFF;
              phase_d = ALARM_OFF_SLOTS;
            end else begin
              state_d = ST_ON;
              phase_d = ALARM_ON_SLOTS;
            end
          end
          SRC_CHIME: begin
            if (phase_q != 2'd1) begin
              phase_d = phase_q - 2'd1;
            end else if (state_q == ST_ON) begin
              state_d = ST_OFF;
              phase_d = CHIME_OFF;
            end else if (beeps_q <= 4'd1) begin
              go_idle = 1'b1;
            end else begin
              beeps_d = beeps_q - 4'd1;
              state_d = ST_ON;
              phase_d = CHIME_ON;
            end
          end
          default: go_idle = 1'b1;
        endcase
      end
      if (go_idle) begin
        state_d = ST_IDLE;
        src_d   = SRC_NONE;
        phase_d = '0;
        beeps_d = '0;
      end
    end

    // A request pulse that did not start this cycle waits; a newer chime hour wins.
    if (bus.req_chime && !chime_take) begin
      chime_pend_d = 1'b1;
      chime_hour_d = hour_in;
    end
    if (bus.req_key && !key_take) begin
      key_pend_d = 1'b1;
    end
  end

  // Outputs: tone only while ON; source visible through ON and OFF.
  always_comb begin
    bus.tone_half  = (state_q == ST_ON) ? half_of(src_q) : 18'd0;
    bus.active_src = src_q;
    bus.busy       = (src_q != SRC_NONE);
    bus.state_dbg  = state_q;
  end

  buzzer_tone_gen u_tone (
    .CLK       (CLK),
    .nRST      (nRST),
    .tone_half (bus.tone_half),
    .BUZZER    (bus.BUZZER)
  );

endmodule
